snake_move_controller: RTL and testbench

Sequences the snake-game state that the VGA renderer draws. Once every TICK_FRAMES video frames it:
- advances the snake one cell in the latched direction,
- checks wall and self collision with a serial body walk,
- grows the snake when the head lands on the apple,
- publishes head, length, per-segment direction list and stage.

All state updates start at the frame boundary (iVS falling edge) and finish within vertical blank, so the renderer never sees a half-updated snake.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/snake_step.sv | 39 +++
 rtl/snake_move_controller.sv | 248 ++++++++++++++++++++++++
 tb/tb_snake_move_controller.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller.
// Holds the direction and stage codes, the default board size, and the
// helper that converts a direction into a signed step on the board.
package snake_pkg;

    localparam int BOARD_W_DEFAULT = 40;
    localparam int BOARD_H_DEFAULT = 40;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [31:0] STAGE_IDLE = 32'd0;
    localparam logic [31:0] STAGE_PLAY = 32'd2;
    localparam logic [31:0] STAGE_OVER = 32'd3;

    // Board positions are row*board_w + col, so a vertical step is +/- board_w.
    function automatic logic signed [31:0] dir_offset(input logic [1:0] dir,
                                                      input int board_w);
        logic signed [31:0] off;
        case (dir)
            DIR_UP:    off = -board_w;
            DIR_RIGHT: off = 32'sd1;
            DIR_DOWN:  off = board_w;
            default:   off = -32'sd1;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/snake_step.sv
// One board step: next position for a direction plus the wall-hit flag.
// Purely combinational; the controller muxes the head (MOVE) or the body
// walker (CHECK) onto it.
//   pos_i      : current board position
//   dir_i      : direction code
//   next_pos_o : pos_i + offset(dir_i), only meaningful when no wall hit
//   wall_hit_o : the step would leave the board
module snake_step
    import snake_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEFAULT,
    parameter int BOARD_H = BOARD_H_DEFAULT
) (
    input  logic [31:0] pos_i,
    input  logic [1:0]  dir_i,
    output logic [31:0] next_pos_o,
    output logic        wall_hit_o
);

    localparam logic [31:0] W_U      = 32'(BOARD_W);
    localparam logic [31:0] LAST_ROW = 32'(BOARD_W * (BOARD_H - 1));

    logic [31:0] col;

    assign col        = pos_i % W_U;
    assign next_pos_o = pos_i + $unsigned(dir_offset(dir_i, BOARD_W));

    // Walls are judged on the current position, so the wrapped sum above is
    // never committed.
    always_comb begin
        case (dir_i)
            DIR_UP:    wall_hit_o = (pos_i < W_U);
            DIR_RIGHT: wall_hit_o = (col == W_U - 32'd1);
            DIR_DOWN:  wall_hit_o = (pos_i >= LAST_ROW);
            default:   wall_hit_o = (col == 32'd0);
        endcase
    end

endmodule

// File: rtl/snake_move_controller.sv
// Snake game move sequencer. Every TICK_FRAMES frames (counted on iVS
// falling edges) it steps the head, walks the body serially for a self
// collision, and commits head/length/direction list within vertical blank.
//   iVGA_CLK, iRST_n : pixel clock, async active-low reset
//   iVS              : vertical sync, active low
//   up/down/left/right : direction keys (level)
//   iStart           : start / restart from IDLE or OVER
//   iApplePos        : apple board position
//   oHead, oLength, oDirs, oStage : published game state
//   oAteApple        : one-cycle pulse when the head lands on the apple
//   oBusy            : update in progress (MOVE/CHECK/COMMIT)
//
// state     | meaning
// ----------+----------------------------------------------------
// S_IDLE    | waiting for iStart, stage 0
// S_WAIT    | counting frames towards the next move tick
// S_MOVE    | compute new head, wall check, apple check
// S_CHECK   | one body segment compared against new head per cycle
// S_COMMIT  | publish new head, shift direction list, grow
// S_OVER    | game over, state frozen until iStart
module snake_move_controller
    import snake_pkg::*;
#(
    parameter int BOARD_W     = BOARD_W_DEFAULT,
    parameter int BOARD_H     = BOARD_H_DEFAULT,
    parameter int MAX_LEN     = 50,
    parameter int TICK_FRAMES = 8,
    parameter int START_POS   = 820,
    parameter int START_LEN   = 3
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST_n,
    input  logic                 iVS,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
    input  logic                 iStart,
    input  logic [31:0]          iApplePos,
    output logic [31:0]          oHead,
    output logic [31:0]          oLength,
    output logic [2*MAX_LEN-1:0] oDirs,
    output logic [31:0]          oStage,
    output logic                 oAteApple,
    output logic                 oBusy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_MOVE   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam logic [31:0] TICK_LAST   = 32'(TICK_FRAMES - 1);
    localparam logic [31:0] MAX_LEN_U   = 32'(MAX_LEN);
    localparam logic [31:0] START_POS_U = 32'(START_POS);
    localparam logic [31:0] START_LEN_U = 32'(START_LEN);
    localparam logic [2*MAX_LEN-1:0] DIRS_INIT = {MAX_LEN{DIR_DOWN}};

    logic [2:0]           state_q, state_d;
    logic                 vs_q;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic [1:0]           heading_q, heading_d;
    logic [1:0]           move_dir_q, move_dir_d;
    logic [31:0]          head_q, head_d;
    logic [31:0]          len_q, len_d;
    logic [2*MAX_LEN-1:0] dirs_q, dirs_d;
    logic [31:0]          stage_q, stage_d;
    logic [31:0]          new_head_q, new_head_d;
    logic                 eat_q, eat_d;
    logic                 grow_q, grow_d;
    logic [31:0]          walk_pos_q, walk_pos_d;
    logic [31:0]          walk_idx_q, walk_idx_d;
    logic [31:0]          check_last_q, check_last_d;

    logic        vs_fall;
    logic        key_valid;
    logic [1:0]  key_dir;
    logic [1:0]  walk_dir;
    logic [31:0] step_pos;
    logic [1:0]  step_dir;
    logic [31:0] step_next;
    logic        step_wall;
    logic        move_eat;

    assign vs_fall = vs_q & ~iVS;

    always_comb begin
        key_valid = up | right | down | left;
        if (up)         key_dir = DIR_UP;
        else if (right) key_dir = DIR_RIGHT;
        else if (down)  key_dir = DIR_DOWN;
        else            key_dir = DIR_LEFT;
    end

    always_comb begin
        walk_dir = DIR_UP;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (walk_idx_q == 32'(i)) walk_dir = dirs_q[2*i +: 2];
        end
    end

    // One stepper shared by the head step (MOVE) and the body walker (CHECK).
    assign step_pos = (state_q == S_CHECK) ? walk_pos_q : head_q;
    assign step_dir = (state_q == S_CHECK) ? walk_dir   : heading_q;
    assign move_eat = (step_next == iApplePos);

    snake_step #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H)
    ) u_step (
        .pos_i      (step_pos),
        .dir_i      (step_dir),
        .next_pos_o (step_next),
        .wall_hit_o (step_wall)
    );

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        heading_d    = heading_q;
        move_dir_d   = move_dir_q;
        head_d       = head_q;
        len_d        = len_q;
        dirs_d       = dirs_q;
        stage_d      = stage_q;
        new_head_d   = new_head_q;
        eat_d        = eat_q;
        grow_d       = grow_q;
        walk_pos_d   = walk_pos_q;
        walk_idx_d   = walk_idx_q;
        check_last_d = check_last_q;

        // Reversal is judged against the latched heading, not the last move.
        if (state_q != S_IDLE && state_q != S_OVER && key_valid &&
            key_dir != (heading_q ^ 2'b10)) begin
            heading_d = key_dir;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (iStart) begin
                    head_d      = START_POS_U;
                    len_d       = START_LEN_U;
                    dirs_d      = DIRS_INIT;
                    heading_d   = DIR_UP;
                    frame_cnt_d = 32'd0;
                    stage_d     = STAGE_PLAY;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vs_fall) begin
                    if (frame_cnt_q == TICK_LAST) begin
                        frame_cnt_d = 32'd0;
                        state_d     = S_MOVE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                    end
                end
            end
            S_MOVE: begin
                new_head_d = step_next;
                eat_d      = move_eat;
                grow_d     = move_eat && (len_q < MAX_LEN_U);
                // The direction used is frozen here; keys may change heading
                // while the body walk is still running.
                move_dir_d = heading_q;
                walk_pos_d = head_q;
                walk_idx_d = 32'd0;
                // The tail only vacates its cell when the snake does not grow.
                check_last_d = move_eat ? (len_q - 32'd1) : (len_q - 32'd2);
                if (step_wall) begin
                    stage_d = STAGE_OVER;
                    state_d = S_OVER;
                end else if (!move_eat && len_q < 32'd2) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (walk_pos_q == new_head_q) begin
                    stage_d = STAGE_OVER;
                    state_d = S_OVER;
                end else if (walk_idx_q == check_last_q) begin
                    state_d = S_COMMIT;
                end else begin
                    walk_pos_d = step_next;
                    walk_idx_d = walk_idx_q + 32'd1;
                end
            end
            S_COMMIT: begin
                head_d = new_head_q;
                dirs_d = {dirs_q[2*MAX_LEN-3:0], move_dir_q ^ 2'b10};
                if (grow_q) len_d = len_q + 32'd1;
                state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= S_IDLE;
            vs_q         <= 1'b1;
            frame_cnt_q  <= 32'd0;
            heading_q    <= DIR_UP;
            move_dir_q   <= DIR_UP;
            head_q       <= START_POS_U;
            len_q        <= START_LEN_U;
            dirs_q       <= DIRS_INIT;
            stage_q      <= STAGE_IDLE;
            new_head_q   <= 32'd0;
            eat_q        <= 1'b0;
            grow_q       <= 1'b0;
            walk_pos_q   <= 32'd0;
            walk_idx_q   <= 32'd0;
            check_last_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            vs_q         <= iVS;
            frame_cnt_q  <= frame_cnt_d;
            heading_q    <= heading_d;
            move_dir_q   <= move_dir_d;
            head_q       <= head_d;
            len_q        <= len_d;
            dirs_q       <= dirs_d;
            stage_q      <= stage_d;
            new_head_q   <= new_head_d;
            eat_q        <= eat_d;
            grow_q       <= grow_d;
            walk_pos_q   <= walk_pos_d;
            walk_idx_q   <= walk_idx_d;
            check_last_q <= check_last_d;
        end
    end

    assign oHead     = head_q;
    assign oLength   = len_q;
    assign oDirs     = dirs_q;
    assign oStage    = stage_q;
    assign oAteApple = (state_q == S_COMMIT) && eat_q;
    assign oBusy     = (state_q == S_MOVE) || (state_q == S_CHECK) ||
                       (state_q == S_COMMIT);

endmodule

// File: tb/tb_snake_move_controller.sv
// Bench for snake_move_controller: a position-list model of the snake
// predicts each move; predictions are queued when a move is driven and
// compared once the frames for that move have elapsed.
module tb_snake_move_controller;

    localparam int W       = 40;
    localparam int H       = 40;
    localparam int MAX_LEN = 50;
    localparam int TICK    = 8;
    localparam int START   = 820;
    localparam int DW      = 2 * MAX_LEN;

    typedef logic [DW-1:0] dirs_t;

    typedef struct {
        int    head;
        int    len;
        int    stage;
        int    ate;
        int    busy;
        dirs_t dirs;
        dirs_t mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, vs, k_up, k_down, k_left, k_right, start;
    logic [31:0] apple;
    logic [31:0] o_head, o_len, o_stage;
    dirs_t       o_dirs;
    logic        o_ate, o_busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cnt = 0;
    int   ate_cnt  = 0;
    exp_t sb_q[$];

    int   m_body[$];
    int   m_heading;
    int   m_stage;

    always #5 clk = ~clk;

    snake_move_controller #(
        .BOARD_W     (W),
        .BOARD_H     (H),
        .MAX_LEN     (MAX_LEN),
        .TICK_FRAMES (TICK),
        .START_POS   (START),
        .START_LEN   (3)
    ) dut (
        .iVGA_CLK  (clk),
        .iRST_n    (rst_n),
        .iVS       (vs),
        .up        (k_up),
        .down      (k_down),
        .left      (k_left),
        .right     (k_right),
        .iStart    (start),
        .iApplePos (apple),
        .oHead     (o_head),
        .oLength   (o_len),
        .oDirs     (o_dirs),
        .oStage    (o_stage),
        .oAteApple (o_ate),
        .oBusy     (o_busy)
    );

    always @(negedge clk) begin
        if (o_busy) busy_cnt++;
        if (o_ate)  ate_cnt++;
    end

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int offset_of(input int d);
        case (d)
            0:       return -W;
            1:       return 1;
            2:       return W;
            default: return -1;
        endcase
    endfunction

    function automatic int dir_of(input int delta);
        if (delta == -W) return 0;
        if (delta == 1)  return 1;
        if (delta == W)  return 2;
        return 3;
    endfunction

    function automatic void model_start();
        m_body.delete();
        m_body.push_back(START);
        m_body.push_back(START + W);
        m_body.push_back(START + 2 * W);
        m_heading = 0;
        m_stage   = 2;
    endfunction

    function automatic int model_next(input int key);
        int h;
        h = m_heading;
        if (key >= 0 && key != (m_heading ^ 2)) h = key;
        return m_body[0] + offset_of(h);
    endfunction

    function automatic void model_move(input int key, input int apple_pos,
                                       output exp_t e);
        int head, len, nh, n, hit;
        bit wall, eat;
        head = m_body[0];
        len  = m_body.size();
        if (key >= 0 && key != (m_heading ^ 2)) m_heading = key;
        case (m_heading)
            0:       wall = (head < W);
            1:       wall = (head % W == W - 1);
            2:       wall = (head >= W * (H - 1));
            default: wall = (head % W == 0);
        endcase
        nh    = head + offset_of(m_heading);
        eat   = (nh == apple_pos);
        e.ate = 0;
        if (wall) begin
            m_stage = 3;
            e.busy  = 1;
        end else begin
            n   = eat ? len : len - 1;
            hit = -1;
            for (int k = 0; k < n; k++)
                if (hit < 0 && m_body[k] == nh) hit = k;
            if (hit >= 0) begin
                m_stage = 3;
                e.busy  = 2 + hit;
            end else begin
                e.busy = n + 2;
                e.ate  = eat ? 1 : 0;
                m_body.push_front(nh);
                if (!(eat && len < MAX_LEN)) void'(m_body.pop_back());
            end
        end
        e.head  = m_body[0];
        e.len   = m_body.size();
        e.stage = m_stage;
        e.dirs  = '0;
        e.mask  = '0;
        for (int k = 0; k < m_body.size() - 1; k++) begin
            e.dirs = e.dirs | (dirs_t'(dir_of(m_body[k+1] - m_body[k])) << (2 * k));
            e.mask = e.mask | (dirs_t'(3) << (2 * k));
        end
    endfunction

    task automatic set_keys(input int key);
        k_up    = (key == 0);
        k_right = (key == 1);
        k_down  = (key == 2);
        k_left  = (key == 3);
    endtask

    task automatic frame();
        vs = 1'b0;
        repeat (2) @(negedge clk);
        vs = 1'b1;
        repeat (62) @(negedge clk);
    endtask

    task automatic check_move();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 128'(sb_q.size()), 128'(1));
            return;
        end
        e = sb_q.pop_front();
        check_eq("busy_done", 128'(o_busy), 128'(0));
        check_eq("head", 128'(o_head), 128'(e.head));
        check_eq("length", 128'(o_len), 128'(e.len));
        check_eq("stage", 128'(o_stage), 128'(e.stage));
        check_eq("dirs", 128'(o_dirs & e.mask), 128'(e.dirs));
        check_eq("ate_pulses", 128'(ate_cnt), 128'(e.ate));
        check_eq("busy_cycles", 128'(busy_cnt), 128'(e.busy));
    endtask

    task automatic do_move(input int key, input int apple_pos);
        exp_t e;
        set_keys(key);
        apple = 32'(apple_pos);
        model_move(key, apple_pos, e);
        sb_q.push_back(e);
        busy_cnt = 0;
        ate_cnt  = 0;
        repeat (TICK) frame();
        set_keys(-1);
        check_move();
    endtask

    task automatic eat_move(input int key);
        do_move(key, model_next(key));
    endtask

    task automatic check_reset(input string tag);
        dirs_t all_down;
        all_down = '0;
        for (int k = 0; k < MAX_LEN; k++) all_down = all_down | (dirs_t'(2) << (2 * k));
        check_eq({tag, "_head"}, 128'(o_head), 128'(START));
        check_eq({tag, "_len"}, 128'(o_len), 128'(3));
        check_eq({tag, "_dirs"}, 128'(o_dirs), 128'(all_down));
        check_eq({tag, "_stage"}, 128'(o_stage), 128'(0));
        check_eq({tag, "_busy"}, 128'(o_busy), 128'(0));
        check_eq({tag, "_ate"}, 128'(o_ate), 128'(0));
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
        check_eq({tag, "_stage"}, 128'(o_stage), 128'(2));
        check_eq({tag, "_head"}, 128'(o_head), 128'(START));
        check_eq({tag, "_len"}, 128'(o_len), 128'(3));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic reset_mid_check();
        int waited;
        waited = 0;
        apple  = 32'd0;
        repeat (TICK - 1) frame();
        vs = 1'b0;
        while (!o_busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("busy_seen", 128'(o_busy), 128'(1));
        repeat (5) @(negedge clk);
        check_eq("still_checking", 128'(o_busy), 128'(1));
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        vs = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        vs    = 1'b1;
        start = 1'b0;
        apple = 32'd0;
        set_keys(-1);
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Frames while idle must not move anything.
        repeat (TICK) frame();
        check_eq("idle_head", 128'(o_head), 128'(START));
        check_eq("idle_stage", 128'(o_stage), 128'(0));

        // Plain move, ignored reversal, then a turn.
        do_start("start_a");
        do_move(-1, 0);
        do_move(2, 0);
        do_move(1, 0);

        // Grow to the length limit, then eat once more at the limit.
        pulse_reset();
        do_start("start_b");
        eat_move(-1);
        for (int i = 0; i < 17; i++) eat_move(0);
        for (int i = 0; i < 10; i++) eat_move(1);
        for (int i = 0; i < 19; i++) eat_move(2);
        check_eq("len_at_max", 128'(o_len), 128'(MAX_LEN));
        eat_move(2);
        reset_mid_check();

        // Right wall at column 39, then restart.
        do_start("start_c");
        do_move(-1, 0);
        for (int i = 0; i < 19; i++) do_move(1, 0);
        do_move(1, 0);
        do_start("restart_c");

        // Length 5 loop collides with its own body.
        eat_move(-1);
        eat_move(-1);
        do_move(1, 0);
        do_move(2, 0);
        do_move(3, 0);
        do_start("restart_d");

        // Length 4 loop lands on the vacating tail.
        eat_move(-1);
        do_move(1, 0);
        do_move(2, 0);
        do_move(3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
